// File: rtl/counter.sv
// Iteration down-counter for the shift-add multiplier: Load presets ITERATIONS, K flags exhaustion.
// Optional macro COUNTER_DEBUG_EN exposes the internal count on output port Count.
module counter #(
  parameter int ITERATIONS = 32,
  parameter int WIDTH      = 6
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Load,
  output logic             K
`ifdef COUNTER_DEBUG_EN
  ,
  output logic [WIDTH-1:0] Count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] PRESET = WIDTH'(ITERATIONS);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  state_t           state, state_next;
  logic [WIDTH-1:0] count, count_next;
  logic             k_q, k_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      count <= '0;
      k_q   <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      k_q   <= k_next;
    end
  end

  // NOTE: every output of this block is defaulted first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    count_next = count;
    k_next     = k_q;

    if (Load) begin
      state_next = RUN;
      count_next = PRESET;
      k_next     = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          count_next = '0;
          k_next     = 1'b0;
        end
        RUN: begin
          // A count of 0 cannot occur in RUN; treat it like 1 rather than wrap.
          if (count > ONE) begin
            count_next = count - ONE;
            k_next     = 1'b0;
          end else begin
            state_next = DONE;
            count_next = '0;
            k_next     = 1'b1;
          end
        end
        DONE: begin
          count_next = '0;
          k_next     = 1'b1;
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
          k_next     = 1'b0;
        end
      endcase
    end
  end

  assign K = k_q;

`ifdef COUNTER_DEBUG_EN
  assign Count = count;
`endif

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: default ITERATIONS=32 instance plus an ITERATIONS=1/WIDTH=1 corner.
// Expected K/count come from an "edges since last load" model held in a scoreboard queue.
module tb_counter;

  localparam int ITER0 = 32;
  localparam int W0    = 6;
  localparam int ITER1 = 1;
  localparam int W1    = 1;

  logic          clk;
  logic          rst_n;
  logic          load;
  logic          k0, k1;
  logic [W0-1:0] cnt0;
  logic [W1-1:0] cnt1;

  counter #(.ITERATIONS(ITER0), .WIDTH(W0)) dut (
    .Clk  (clk),
    .Rst  (rst_n),
    .Load (load),
    .K    (k0)
`ifdef COUNTER_DEBUG_EN
    ,
    .Count(cnt0)
`endif
  );

  counter #(.ITERATIONS(ITER1), .WIDTH(W1)) dut1 (
    .Clk  (clk),
    .Rst  (rst_n),
    .Load (load),
    .K    (k1)
`ifdef COUNTER_DEBUG_EN
    ,
    .Count(cnt1)
`endif
  );

`ifndef COUNTER_DEBUG_EN
  assign cnt0 = dut.count;
  assign cnt1 = dut1.count;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          k0;
    logic [W0-1:0] cnt0;
    logic          k1;
    logic [W1-1:0] cnt1;
  } exp_t;

  exp_t exp_q[$];

  int passed = 0;
  int total  = 0;

  // Reference model: edges with Load=0 since the last Load edge.
  bit loaded = 1'b0;
  int edges  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    e.k0   = loaded && (edges >= ITER0);
    e.cnt0 = (!loaded || edges >= ITER0) ? '0 : W0'(ITER0 - edges);
    e.k1   = loaded && (edges >= ITER1);
    e.cnt1 = (!loaded || edges >= ITER1) ? '0 : W1'(ITER1 - edges);
    return e;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_k"},     32'(k0),   32'(e.k0));
      check({tag, "_count"}, 32'(cnt0), 32'(e.cnt0));
      check({tag, "_k1"},    32'(k1),   32'(e.k1));
      check({tag, "_count1"},32'(cnt1), 32'(e.cnt1));
    end
  endtask

  // One clock: drive Load away from the edge, update the model at the edge, compare #1 later.
  task automatic step(input logic ld, input string tag);
    @(negedge clk);
    load = ld;
    @(posedge clk);
    if (!rst_n) begin
      loaded = 1'b0;
      edges  = 0;
    end else if (ld) begin
      loaded = 1'b1;
      edges  = 0;
    end else if (loaded && edges < 1000) begin
      edges++;
    end
    exp_q.push_back(model_expect());
    #1;
    compare(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;

    // Reset held with Load toggling.
    #2;
    check("reset_async_k", 32'(k0), 32'd0);
    check("reset_async_count", 32'(cnt0), 32'd0);
    for (int i = 0; i < 5; i++) step(i[0], "reset_hold");

    // Release; first edge behaves as IDLE.
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, "idle");
    step(1'b0, "idle");

    // Basic count plus 20 edges holding in DONE.
    step(1'b1, "load");
    for (int i = 1; i <= ITER0; i++) step(1'b0, "basic");
    for (int i = 0; i < 20; i++) step(1'b0, "done_hold");

    // Restart mid-run.
    step(1'b1, "load2");
    for (int i = 0; i < 10; i++) step(1'b0, "run10");
    step(1'b1, "reload");
    for (int i = 1; i <= ITER0 + 2; i++) step(1'b0, "restart");

    // Reload from DONE with Load held for 5 edges.
    for (int i = 0; i < 5; i++) step(1'b1, "load_held");
    for (int i = 1; i <= ITER0 + 2; i++) step(1'b0, "after_held");

    // Async reset mid-run, between clock edges.
    step(1'b1, "load3");
    for (int i = 0; i < 5; i++) step(1'b0, "pre_reset");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_count", 32'(cnt0), 32'd0);
    check("midrun_reset_k", 32'(k0), 32'd0);
    step(1'b1, "reset_load_ignored");

    // Reset asserted while K is high clears it immediately.
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, "load4");
    for (int i = 1; i <= ITER0; i++) step(1'b0, "to_done");
    check("k_high_before_reset", 32'(k0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("done_reset_k", 32'(k0), 32'd0);
    check("done_reset_k1", 32'(k1), 32'd0);
    step(1'b0, "post_reset");

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/counter.md
# counter

Iteration counter for the sequential shift-add multiplier in the MIPS CPU datapath. On `Load` it presets a down-counter to the iteration count (one per multiplier bit) and then decrements once per clock. When the count reaches zero it raises the terminal flag `K`, which tells the multiplier control FSM to stop shifting and report the product.

## Interface
- `ITERATIONS`, default 32: number of multiply iterations loaded on `Load`; legal range 1 to 2^WIDTH−1.
- `WIDTH`, default 6: counter register width; must satisfy 2^WIDTH > ITERATIONS.
- `Clk` input 1: single clock; all state updates on rising edge.
- `Rst` input 1: reset, asynchronous and active-low (asserted when 0).
- `Load` input 1: synchronous preset/start request, sampled on rising `Clk`.
- `K` output 1: registered terminal-count flag; 1 when the loaded count has been exhausted.

## Operation
- Internal state: `count[WIDTH-1:0]` and a three-state FSM:
  - IDLE: after reset, before any load.
  - RUN: counting down.
  - DONE: terminal count reached.
- Reset (`Rst`=0, asynchronous, overrides everything): `count`=0, state=IDLE, `K`=0. While `Rst` is held low, `Load` and `Clk` are ignored.
- `Load`=1 at a rising edge, in any state: `count` <= ITERATIONS, state <= RUN, `K` <= 0. Load has priority over decrement.
- RUN with `Load`=0:
  - If `count` > 1: `count` <= `count`−1, `K` stays 0.
  - If `count` = 1: `count` <= 0, state <= DONE, `K` <= 1.
- DONE with `Load`=0: hold `count`=0 and `K`=1. No wrap-around, and no further decrement.
- IDLE with `Load`=0: hold `count`=0 and `K`=0. IDLE never asserts `K`.
- `Load` held high for multiple edges: `count` is re-preset each edge and stays at ITERATIONS. Counting starts on the first edge with `Load`=0.
- Unreachable FSM encodings recover to IDLE with `K`=0.

## Timing
- `K` is a registered output; no combinational path from `Load` to `K`.
- Let E0 be the last rising edge with `Load`=1. For each subsequent edge Ei with `Load`=0:
  - `count` = ITERATIONS − i.
  - `K` rises on edge E_ITERATIONS (32 clocks after E0 by default) and stays high.
- `Load` reasserted mid-RUN or in DONE: `K` falls (or stays low) on that edge, and the full ITERATIONS-cycle sequence restarts.
- Reset asserted mid-operation: `K` and `count` clear immediately, without waiting for a clock edge.
- Reset deassertion must be synchronised externally. The first edge after release behaves as IDLE.

## Configuration
- Macro `COUNTER_DEBUG_EN`:
  - Defined: adds output port `Count`, direction output, width WIDTH, driven directly by the internal `count` register (reset value 0). Used for waveform and scoreboard checks.
  - Not defined: the port does not exist, and the port list is exactly `Clk`, `Rst`, `Load`, `K`.
- Functional behaviour of `K` is identical in both builds.

## Test plan
- Reset: drive `Rst`=0 with `Load` toggling for 5 clocks → `K`=0 throughout and `Count`=0. Asserting `Rst`=0 between clock edges clears `K` immediately.
- Basic count: release reset, pulse `Load`=1 for one edge, then hold `Load`=0 → `K`=0 for edges 1–31 after the load and `K`=1 from edge 32 on. With the debug build, `Count` steps 32, 31, …, 1, 0.
- Hold in DONE: after `K`=1, run 20 more clocks with `Load`=0 → `K` stays 1 and `Count` stays 0, with no wrap to 2^WIDTH−1.
- Restart mid-run: load, run 10 clocks, pulse `Load` again → `Count`=32 and `K`=0, and `K` rises exactly 32 edges after the second load.
- Load held: keep `Load`=1 for 5 edges, then drop it → `Count` stays 32 while held, and `K` rises 32 edges after the last high edge.
- Parameter corner: ITERATIONS=1, WIDTH=1 → `K` rises on the first edge after the load edge.
